approx_mul_err_monitor: RTL
===========================

// Module: approx_mul_err_monitor
// PURPOSE
//  On-chip result checker for the signed approximate multipliers (FABM family).
//  Accepts operand pairs plus the DUT's approximate product, recomputes the exact signed
//  product, and accumulates error statistics: erroneous count, sum |ED|, max |ED|.
//  Sits downstream of the multiplier and the operand source. Replaces offline dump-and-compare
//  with a hardware run-length measurement.
// PARAMETERS
//  N      32   operand width (signed, two's complement)
//  CNT_W  32   width of sample and error counters
//  SUM_W  96   width of the sum-of-absolute-error accumulator (saturating)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       pulse: clear stats, latch num_samples, begin run
//  num_samples  in   CNT_W   samples to accept in this run; sampled on start
//  in_valid     in   1       in_a/in_b/in_prod valid
//  in_ready     out  1       monitor accepts a sample when in_valid & in_ready
//  in_a         in   N       multiplicand, signed
//  in_b         in   N       multiplier, signed
//  in_prod      in   2N      approximate product under test, signed
//  busy         out  1       run in progress (RUN or DRAIN)
//  done         out  1       stats final; held until next start or rst
//  sample_cnt   out  CNT_W   samples accumulated so far
//  err_cnt      out  CNT_W   samples with in_prod != exact product
//  sum_abs_err  out  SUM_W   sum of |exact - in_prod|, saturates at all-ones
//  max_abs_err  out  2N      maximum |exact - in_prod| seen this run
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=0, busy=0, done=0; all counters/accumulators 0; pipeline valids 0.
//  - FSM: IDLE -start-> RUN (num_samples!=0) or DONE (num_samples==0, all stats 0).
//    RUN: in_ready=1 while accepted<num_samples; the handshake that makes accepted==num_samples
//    moves to DRAIN. DRAIN: in_ready=0; once all pipeline valids are 0 -> DONE.
//    DONE: done=1, in_ready=0; stats stable. start -> as from IDLE.
//  - start in any state (incl. RUN/DRAIN) has priority: clears stats, flushes pipeline valids,
//    relatches num_samples; a handshake in the same cycle as start is discarded.
//  - Pipeline, 3 stages, fixed: S1 registers a, b, prod on accept. S2 registers
//    exact = $signed(a)*$signed(b) (2N bits, exact) and prod. S3 registers
//    d = exact - prod (2N+1 bits signed) and ad = |d| truncated to 2N bits (lossless:
//    |d| <= 3*2^(2N-2)). Stats update on the cycle after S3 valid: sample_cnt+1,
//    err_cnt+(ad!=0), sum_abs_err += ad (saturating), max_abs_err = max(max, ad).
//    Accept at cycle t -> sample_cnt reflects it at t+4.
//  - Throughput one sample/cycle; no back-pressure inside pipeline.
//  - in_valid with in_ready=0 is ignored (no data captured).
//  - sample_cnt/err_cnt never wrap: num_samples <= 2^CNT_W-1 bounds them.
//  - done asserts the cycle after the last sample's stats update; busy deasserts same cycle.
//  - rst mid-run: immediate return to reset values; partial stats discarded.
// TESTING
//  1 Exact DUT: num_samples=4, prod=a*b for (3,5),(-7,9),(-2^31,-2^31),(0,123) -> done,
//    sample_cnt=4, err_cnt=0, sum=0, max=0.
//  2 Errors: num_samples=3, (a,b,prod)=(10,10,96),(-4,8,-30),(1,1,1) -> err_cnt=2, sum=6, max=4.
//  3 Extremes: a=b=-2^31, prod=-2^63 -> max_abs_err=3*2^62, sum=3*2^62, err_cnt=1.
//  4 Throughput/latency: 1000 back-to-back valids (in_valid held 1) -> in_ready drops after
//    1000th handshake, done asserts exactly 4 cycles later, sample_cnt=1000; extra valids ignored.
//  5 Bubbles: in_valid toggled randomly, num_samples=50 -> stats equal software model of
//    accepted samples only.
//  6 Restart/reset: start at sample 20 of 50-run -> stats restart from 0, final sample_cnt=50;
//    rst mid-run -> all outputs 0, IDLE; start with num_samples=0 -> done next cycle, stats 0.

Source files
------------

// File: rtl/approx_mul_err_monitor.sv
// ---------------------------------------------------------------------------
// approx_mul_err_monitor
//
// On-chip result checker for signed approximate multipliers. Each accepted
// sample carries the operands and the approximate product under test. The
// monitor recomputes the exact signed product and accumulates run statistics:
// the number of samples, the number of erroneous samples, the saturating sum
// of |exact - approx| and the maximum |exact - approx|.
//
// Ports
//   clk, rst       clock (rising edge) and synchronous active-high reset
//   start          pulse: clear stats, latch num_samples, begin a run
//   num_samples    samples to accept in this run (sampled on start)
//   in_valid       sample valid (in_a, in_b, in_prod)
//   in_ready       monitor can accept a sample this cycle
//   in_a, in_b     signed operands, N bits
//   in_prod        signed approximate product, 2N bits
//   busy           run in progress (RUN or DRAIN)
//   done           statistics final, held until the next start or rst
//   sample_cnt     samples accumulated so far
//   err_cnt        samples whose in_prod differs from the exact product
//   sum_abs_err    sum of |exact - in_prod|, saturates at all-ones
//   max_abs_err    largest |exact - in_prod| seen this run
//   dbg_state_o    current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshake: a sample is transferred on a rising edge where in_valid and
// in_ready are both 1 and start is 0. in_ready does not depend on in_valid.
// in_valid while in_ready is 0 is ignored; a transfer coinciding with start
// is discarded because start restarts the run.
// ---------------------------------------------------------------------------
module approx_mul_err_monitor #(
    parameter int N     = 32,
    parameter int CNT_W = 32,
    parameter int SUM_W = 96
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_a,
    input  logic [N-1:0]       in_b,
    input  logic [2*N-1:0]     in_prod,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [SUM_W-1:0]   sum_abs_err,
    output logic [2*N-1:0]     max_abs_err,
    output logic [1:0]         dbg_state_o
);

    localparam int W2 = 2 * N;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] accepted_q;
    logic             run_open;
    logic             accept;

    // Pipeline registers
    logic             s1_v_q, s2_v_q, s3_v_q;
    logic [N-1:0]     a1_q, b1_q;
    logic [W2-1:0]    p1_q;
    logic [W2-1:0]    exact2_q, p2_q;
    logic [W2-1:0]    ad3_q;

    // Statistics
    logic [CNT_W-1:0] sample_cnt_q, err_cnt_q;
    logic [SUM_W-1:0] sum_q;
    logic [W2-1:0]    max_q;

    // Combinational datapath
    logic signed [W2-1:0] a_ext, b_ext;
    logic        [W2-1:0] exact_d;
    logic        [W2:0]   diff;
    logic        [W2:0]   neg_diff;
    logic        [W2-1:0] ad_d;
    logic        [SUM_W:0] sum_ext;
    logic        [SUM_W-1:0] sum_d;

    assign run_open = (state_q == ST_RUN) && (accepted_q < num_q);
    assign accept   = in_valid && run_open && !start;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
            end
            ST_RUN: begin
                in_ready = run_open;
                busy     = 1'b1;
                if (accept && ((accepted_q + CNT_W'(1)) == num_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // S1/S2 empty means the last sample sits in S3 and folds into
                // the stats on this edge, so done lines up with the final update.
                if (!s1_v_q && !s2_v_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (start) begin
            state_d = (num_samples == '0) ? ST_DONE : ST_RUN;
        end
    end

    assign dbg_state_o = state_q;

    // ------------------------------------------------------------------
    // Datapath arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        // Sign-extend first so the product is evaluated at full 2N width.
        a_ext    = {{N{a1_q[N-1]}}, a1_q};
        b_ext    = {{N{b1_q[N-1]}}, b1_q};
        exact_d  = a_ext * b_ext;
        // One extra bit keeps exact - prod from overflowing; |d| always fits
        // back into 2N bits, so the truncation below is lossless.
        diff     = {exact2_q[W2-1], exact2_q} - {p2_q[W2-1], p2_q};
        neg_diff = -diff;
        ad_d     = diff[W2] ? neg_diff[W2-1:0] : diff[W2-1:0];
        sum_ext  = {1'b0, sum_q} + {{(SUM_W + 1 - W2){1'b0}}, ad3_q};
        sum_d    = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
    end

    // Data registers carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a1_q <= in_a;
            b1_q <= in_b;
            p1_q <= in_prod;
        end
        exact2_q <= exact_d;
        p2_q     <= p1_q;
        ad3_q    <= ad_d;
    end

    // ------------------------------------------------------------------
    // Control, valids and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q        <= '0;
            accepted_q   <= '0;
            s1_v_q       <= 1'b0;
            s2_v_q       <= 1'b0;
            s3_v_q       <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_q        <= '0;
            max_q        <= '0;
        end else if (start) begin
            num_q        <= num_samples;
            accepted_q   <= '0;
            s1_v_q       <= 1'b0;
            s2_v_q       <= 1'b0;
            s3_v_q       <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_q        <= '0;
            max_q        <= '0;
        end else begin
            s1_v_q <= accept;
            s2_v_q <= s1_v_q;
            s3_v_q <= s2_v_q;
            if (accept) begin
                accepted_q <= accepted_q + CNT_W'(1);
            end
            if (s3_v_q) begin
                sample_cnt_q <= sample_cnt_q + CNT_W'(1);
                if (ad3_q != '0) begin
                    err_cnt_q <= err_cnt_q + CNT_W'(1);
                end
                sum_q <= sum_d;
                if (ad3_q > max_q) begin
                    max_q <= ad3_q;
                end
            end
        end
    end

    assign sample_cnt  = sample_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign sum_abs_err = sum_q;
    assign max_abs_err = max_q;

endmodule
